// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_sram_responder
// Desc    : Wait-stated data SRAM responder with byte-lane writes, window check
//           and pipeline stall for the CPU data-memory port.
// Revision: 1.0 - initial release
// ============================================================================
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        data_ok,
  output logic        bus_err,
  output logic        stall
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_WORD = BASE_ADDR[ADDR_WIDTH+1:2];

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [3:0]            wen_q, wen_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  in_range_q, in_range_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  data_ok_q, data_ok_d;
  logic                  bus_err_q, bus_err_d;
  logic                  req_in_range;
  logic                  commit;

  logic [31:0] mem [DEPTH];

  // The _d copies of the request carry the incoming request on an IDLE
  // acceptance, so a zero-wait commit sees the same values as a delayed one.
  always_comb begin
    req_in_range = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    in_range_d   = in_range_q;
    commit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          idx_d      = addr[ADDR_WIDTH+1:2] - BASE_WORD;
          wen_d      = wen;
          wdata_d    = wdata;
          in_range_d = req_in_range;
          cnt_d      = CNT_INIT;
          if (WAIT_CYCLES > 0) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            commit  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rdata_d   = rdata_q;
    data_ok_d = commit;
    bus_err_d = commit && !in_range_d;
    if (commit) begin
      if (!in_range_d) begin
        rdata_d = '0;
      end else if (wen_d == 4'b0000) begin
        rdata_d = mem[idx_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wen_q      <= '0;
      wdata_q    <= '0;
      in_range_q <= 1'b0;
      rdata_q    <= '0;
      data_ok_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      in_range_q <= in_range_d;
      rdata_q    <= rdata_d;
      data_ok_q  <= data_ok_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Array is never reset; a commit coinciding with reset is dropped whole.
  always_ff @(posedge clk) begin
    if (resetn && commit && in_range_d) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_d[i]) begin
          mem[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
        end
      end
    end
  end

  assign rdata   = rdata_q;
  assign data_ok = data_ok_q;
  assign bus_err = bus_err_q;
  assign stall   = ((state_q == IDLE) && en) || (state_q == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_sram_responder
// Desc    : Directed self-checking bench for data_sram_responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        rstn    [3];
  logic        en_v    [3];
  logic [3:0]  wen_v   [3];
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic [31:0] rdata_v [3];
  logic        dok_v   [3];
  logic        berr_v  [3];
  logic        stall_v [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_w2 (
    .clk(clk), .resetn(rstn[0]), .en(en_v[0]), .wen(wen_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .rdata(rdata_v[0]), .data_ok(dok_v[0]), .bus_err(berr_v[0]),
    .stall(stall_v[0]));

  data_sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_w3 (
    .clk(clk), .resetn(rstn[1]), .en(en_v[1]), .wen(wen_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .rdata(rdata_v[1]), .data_ok(dok_v[1]), .bus_err(berr_v[1]),
    .stall(stall_v[1]));

  data_sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_w0 (
    .clk(clk), .resetn(rstn[2]), .en(en_v[2]), .wen(wen_v[2]), .addr(addr_v[2]),
    .wdata(wdata_v[2]), .rdata(rdata_v[2]), .data_ok(dok_v[2]), .bus_err(berr_v[2]),
    .stall(stall_v[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete access on instance k; entered and left mid low phase.
  task automatic acc(input int k, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d, input int exp_stall,
                     output logic err, output logic [31:0] rd);
    int stalls = 0;
    int n = 0;
    en_v[k] = 1'b1; wen_v[k] = w; addr_v[k] = a; wdata_v[k] = d;
    #1;
    while (!dok_v[k] && n < 40) begin
      if (stall_v[k]) stalls++;
      @(negedge clk); #1;
      n++;
    end
    check("data_ok seen", 32'(dok_v[k]), 32'd1);
    check("stall cycles", 32'(stalls), 32'(exp_stall));
    check("stall in done", 32'(stall_v[k]), 32'd0);
    err = berr_v[k];
    rd  = rdata_v[k];
    en_v[k] = 1'b0; wen_v[k] = 4'b0;
    @(negedge clk); #1;
    check("data_ok one cycle", 32'(dok_v[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e;
    logic [31:0] r;
    int          pulses;
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0; en_v[k] = 1'b0; wen_v[k] = 4'b0;
      addr_v[k] = '0; wdata_v[k] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    check("reset rdata", rdata_v[0], 32'h0);
    check("reset data_ok", 32'(dok_v[0]), 32'd0);
    check("reset bus_err", 32'(berr_v[0]), 32'd0);
    check("reset stall", 32'(stall_v[0]), 32'd0);
    for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
    @(negedge clk); #1;

    // full-word write then read, WAIT_CYCLES=2
    acc(0, 4'hF, 32'h10, 32'hDEADBEEF, 3, e, r);
    check("t1 write bus_err", 32'(e), 32'd0);
    check("t1 write rdata held", r, 32'h0);
    acc(0, 4'h0, 32'h10, 32'h0, 3, e, r);
    check("t1 read rdata", r, 32'hDEADBEEF);
    check("t1 read bus_err", 32'(e), 32'd0);

    // single byte lane then halfword merge
    acc(0, 4'hF, 32'h20, 32'h11223344, 3, e, r);
    acc(0, 4'b0100, 32'h22, 32'hAAAAAAAA, 3, e, r);
    acc(0, 4'h0, 32'h20, 32'h0, 3, e, r);
    check("t2 byte lane", r, 32'h11AA3344);
    acc(0, 4'b1100, 32'h22, 32'h55665566, 3, e, r);
    acc(0, 4'h0, 32'h20, 32'h0, 3, e, r);
    check("t3 halfword", r, 32'h55663344);

    // out of window, no aliasing onto word 0
    acc(0, 4'hF, 32'h0, 32'hCAFE0001, 3, e, r);
    acc(0, 4'hF, 32'h1000, 32'hFFFFFFFF, 3, e, r);
    check("t4 oor write bus_err", 32'(e), 32'd1);
    check("t4 oor write rdata", r, 32'h0);
    acc(0, 4'h0, 32'h0, 32'h0, 3, e, r);
    check("t4 no alias rdata", r, 32'hCAFE0001);
    check("t4 in-range bus_err", 32'(e), 32'd0);
    acc(0, 4'h0, 32'h2000, 32'h0, 3, e, r);
    check("t4 oor read rdata", r, 32'h0);
    check("t4 oor read bus_err", 32'(e), 32'd1);

    // reset during second BUSY cycle, WAIT_CYCLES=3
    acc(1, 4'hF, 32'h40, 32'h0BADF00D, 4, e, r);
    acc(1, 4'h0, 32'h40, 32'h0, 4, e, r);
    check("t5 old value", r, 32'h0BADF00D);
    en_v[1] = 1'b1; wen_v[1] = 4'hF; addr_v[1] = 32'h40; wdata_v[1] = 32'h12345678;
    @(negedge clk); #1;
    check("t5 busy stall", 32'(stall_v[1]), 32'd1);
    @(negedge clk);
    rstn[1] = 1'b0; en_v[1] = 1'b0; wen_v[1] = 4'b0;
    @(negedge clk); #1;
    check("t5 reset stall", 32'(stall_v[1]), 32'd0);
    check("t5 reset data_ok", 32'(dok_v[1]), 32'd0);
    check("t5 reset rdata", rdata_v[1], 32'h0);
    @(negedge clk); #1;
    check("t5 no late data_ok", 32'(dok_v[1]), 32'd0);
    rstn[1] = 1'b1;
    @(negedge clk); #1;
    acc(1, 4'h0, 32'h40, 32'h0, 4, e, r);
    check("t5 write discarded", r, 32'h0BADF00D);

    // WAIT_CYCLES=0, en held high back to back
    acc(2, 4'hF, 32'h10, 32'hA0A0A0A0, 1, e, r);
    acc(2, 4'hF, 32'h14, 32'hB1B1B1B1, 1, e, r);
    en_v[2] = 1'b1; wen_v[2] = 4'h0; addr_v[2] = 32'h10;
    #1;
    check("t6 accept stall", 32'(stall_v[2]), 32'd1);
    check("t6 accept data_ok", 32'(dok_v[2]), 32'd0);
    @(negedge clk); #1;
    check("t6 done data_ok", 32'(dok_v[2]), 32'd1);
    check("t6 read 0x10", rdata_v[2], 32'hA0A0A0A0);
    check("t6 done stall", 32'(stall_v[2]), 32'd0);
    addr_v[2] = 32'h14;
    @(negedge clk); #1;
    check("t6 no duplicate", 32'(dok_v[2]), 32'd0);
    check("t6 second accept stall", 32'(stall_v[2]), 32'd1);
    @(negedge clk); #1;
    check("t6 second data_ok", 32'(dok_v[2]), 32'd1);
    check("t6 read 0x14", rdata_v[2], 32'hB1B1B1B1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (dok_v[2]) pulses++;
    end
    check("t6 pulse rate", 32'(pulses), 32'd4);
    en_v[2] = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
